// File: rtl/fan_pwm_tach.sv
// fan_pwm_tach: fan PWM drive with spin-up kick, debounced tach window counter and stall detection
// Everything runs on ACLK; tach_in is the only asynchronous input and is synchronised before use.
module fan_pwm_tach #(
    parameter int PRESCALE      = 15,
    parameter int TACH_WIN      = 100_000_000,
    parameter int DEB_CYCLES    = 8,
    parameter int KICK_WINDOWS  = 2,
    parameter int STALL_WINDOWS = 2
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic [7:0]  duty,
    input  logic        stall_clr,
    input  logic        tach_in,
    output logic        pwm_out,
    output logic [15:0] tach_count,
    output logic        tach_valid,
    output logic        stall,
    output logic [1:0]  fan_state
);
    localparam int PW = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
    localparam int WW = TACH_WIN > 1 ? $clog2(TACH_WIN) : 1;
    localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    localparam int KW = KICK_WINDOWS > 1 ? $clog2(KICK_WINDOWS) : 1;
    localparam int ZW = STALL_WINDOWS > 1 ? $clog2(STALL_WINDOWS) : 1;

    typedef enum logic [1:0] {OFF = 2'b00, KICK = 2'b01, RUN = 2'b10} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    pwm_cnt, duty_eff;
    logic          tick, wrap;
    logic          s1, s2, deb, fall;
    logic [DW-1:0] deb_cnt;
    logic [WW-1:0] win_cnt;
    logic          term;
    logic [15:0]   edge_cnt;
    logic [KW-1:0] kick_cnt, kick_cnt_nx;
    logic [ZW-1:0] zero_cnt, zero_cnt_nx;
    logic          stall_set;

    assign tick      = pre_cnt == PW'(PRESCALE);
    assign wrap      = tick && pwm_cnt == 8'hFF;
    assign term      = win_cnt == WW'(TACH_WIN - 1);
    assign fall      = deb && !s2 && deb_cnt == DW'(DEB_CYCLES - 1);
    assign fan_state = state;

    // duty_eff only moves on the period boundary so a mid-period write never produces a runt pulse
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            duty_eff <= '0;
            pwm_out  <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap)
                duty_eff <= state == KICK ? 8'hFF : state == RUN ? duty : 8'h00;
            pwm_out <= duty_eff == 8'hFF || pwm_cnt < duty_eff;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            deb        <= 1'b0;
            deb_cnt    <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            tach_count <= '0;
            tach_valid <= 1'b0;
        end else begin
            s1 <= tach_in;
            s2 <= s1;
            if (s2 == deb)
                deb_cnt <= '0;
            else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                deb     <= s2;
                deb_cnt <= '0;
            end else
                deb_cnt <= deb_cnt + 1'b1;
            win_cnt    <= term ? '0 : win_cnt + 1'b1;
            tach_valid <= term;
            if (term)
                tach_count <= edge_cnt;
            // an edge landing on the terminal cycle seeds the next window
            edge_cnt <= term ? {15'd0, fall} :
                        (fall && edge_cnt != 16'hFFFF) ? edge_cnt + 1'b1 : edge_cnt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= OFF;
            kick_cnt <= '0;
            zero_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            state    <= state_nx;
            kick_cnt <= kick_cnt_nx;
            zero_cnt <= zero_cnt_nx;
            stall    <= stall_set || (stall && !stall_clr);
        end
    end

    always_comb begin
        state_nx    = state;
        kick_cnt_nx = kick_cnt;
        zero_cnt_nx = zero_cnt;
        stall_set   = 1'b0;
        case (state)
            OFF: if (enable && duty != 8'd0) begin
                state_nx    = KICK;
                kick_cnt_nx = '0;
            end
            KICK: if (!enable)
                state_nx = OFF;
            else if (term) begin
                if (kick_cnt == KW'(KICK_WINDOWS - 1))
                    state_nx = RUN;
                else
                    kick_cnt_nx = kick_cnt + 1'b1;
            end
            RUN: if (!enable || duty == 8'd0) begin
                state_nx    = OFF;
                zero_cnt_nx = '0;
            end else if (term) begin
                if (edge_cnt != 16'd0)
                    zero_cnt_nx = '0;
                else if (zero_cnt == ZW'(STALL_WINDOWS - 1)) begin
                    // stalled: flag it and retry with a fresh kick
                    stall_set   = 1'b1;
                    state_nx    = KICK;
                    kick_cnt_nx = '0;
                    zero_cnt_nx = '0;
                end else
                    zero_cnt_nx = zero_cnt + 1'b1;
            end
            default: state_nx = OFF;
        endcase
    end
endmodule

// File: tb/tb_fan_pwm_tach.sv
// tb_fan_pwm_tach: scoreboard bench for fan_pwm_tach against a cycle-indexed behavioural model
module tb_fan_pwm_tach;
    localparam int PRE = 0, WIN = 1000, DEB = 2, KWIN = 2, SWIN = 2;

    logic        ACLK = 1'b0, ARESETN = 1'b0, enable = 1'b0, stall_clr = 1'b0, tach_in = 1'b1;
    logic [7:0]  duty = 8'd0;
    logic        pwm_out, tach_valid, stall;
    logic [15:0] tach_count;
    logic [1:0]  fan_state;

    int n_chk = 0, n_fail = 0;
    int tmode = 0, ph = 0, rlen = 0, hi = 0;

    // model state: m_n is the number of clock edges since reset release
    int m_n = 0, m_state = 0, m_kick = 0, m_zero = 0, m_edges = 0, m_duty_eff = 0;
    bit m_pwm = 0, m_valid = 0, m_stall = 0, m_deb = 0, m_s1 = 0;
    bit hist[$];
    int sb[$];

    fan_pwm_tach #(.PRESCALE(PRE), .TACH_WIN(WIN), .DEB_CYCLES(DEB),
                   .KICK_WINDOWS(KWIN), .STALL_WINDOWS(SWIN)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .duty(duty), .stall_clr(stall_clr),
        .tach_in(tach_in), .pwm_out(pwm_out), .tach_count(tach_count), .tach_valid(tach_valid),
        .stall(stall), .fan_state(fan_state));

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit term, boundary, fall, all_diff, set_stall;
        int cnt;
        term     = ((m_n + 1) % WIN) == 0;
        cnt      = (m_n / (PRE + 1)) % 256;
        boundary = ((m_n + 1) % (256 * (PRE + 1))) == 0;
        m_pwm    = (m_duty_eff == 255) || (cnt < m_duty_eff);
        if (boundary)
            m_duty_eff = m_state == 1 ? 255 : m_state == 2 ? int'(duty) : 0;
        fall = 1'b0;
        if (hist.size() >= DEB) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_deb) all_diff = 1'b0;
            if (all_diff) begin
                fall  = m_deb;
                m_deb = !m_deb;
            end
        end
        hist.push_back(m_s1);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_s1 = tach_in;
        set_stall = 1'b0;
        if (m_state == 0) begin
            if (enable && duty != 8'd0) begin m_state = 1; m_kick = 0; end
        end else if (m_state == 1) begin
            if (!enable) m_state = 0;
            else if (term) begin
                m_kick++;
                if (m_kick >= KWIN) m_state = 2;
            end
        end else begin
            if (!enable || duty == 8'd0) begin m_state = 0; m_zero = 0; end
            else if (term) begin
                m_zero = (m_edges == 0) ? m_zero + 1 : 0;
                if (m_zero >= SWIN) begin
                    set_stall = 1'b1; m_state = 1; m_kick = 0; m_zero = 0;
                end
            end
        end
        m_stall = set_stall ? 1'b1 : stall_clr ? 1'b0 : m_stall;
        m_valid = term;
        if (term) begin
            sb.push_back(m_edges);
            m_edges = fall ? 1 : 0;
        end else if (fall && m_edges < 65535)
            m_edges++;
        m_n++;
    endtask

    initial forever begin
        @(posedge ACLK or negedge ARESETN);
        if (!ARESETN) begin
            m_n = 0; m_state = 0; m_kick = 0; m_zero = 0; m_edges = 0; m_duty_eff = 0;
            m_pwm = 0; m_valid = 0; m_stall = 0; m_deb = 0; m_s1 = 0;
            hist.delete(); hist.push_back(1'b0); sb.delete();
        end else
            model_step();
    end

    // monitor: per-cycle outputs against the model, tach_count against the scoreboard
    initial forever begin
        @(negedge ACLK);
        chk("pwm_out", int'(pwm_out), int'(m_pwm));
        chk("fan_state", int'(fan_state), m_state);
        chk("stall", int'(stall), int'(m_stall));
        chk("tach_valid", int'(tach_valid), int'(m_valid));
        if (tach_valid) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL tach_count: valid with count %0d, expected no update (t=%0t)", tach_count, $time);
            end else
                chk("tach_count", int'(tach_count), sb.pop_front());
        end
    end

    // tach pin generator: 0 idle high, 1 period 100, 2 one-cycle glitches, 3 random, 4 fall on terminal
    initial forever begin
        @(negedge ACLK);
        ph++;
        case (tmode)
            1: tach_in = (ph % 100) < 50;
            2: tach_in = (ph % 37) != 0;
            3: if (rlen == 0) begin tach_in = !tach_in; rlen = $urandom_range(1, 60); end
               else rlen--;
            4: tach_in = ((m_n + 4) % WIN) >= 20;
            default: tach_in = 1'b1;
        endcase
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 1100; i++) begin
            @(negedge ACLK);
            if (tach_valid) break;
        end
        chk("tach_valid_seen", int'(tach_valid), 1);
    endtask

    // high cycles over one aligned PWM period; optional duty write mid-period
    task automatic measure(input int nd, output int h);
        for (int i = 0; i < 300 && (m_n % 256) != 1; i++) @(negedge ACLK);
        h = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 100 && nd >= 0) duty = 8'(nd);
            h += int'(pwm_out);
            @(negedge ACLK);
        end
    endtask

    initial begin
        #12;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_count", int'(tach_count), 0);
        chk("rst_valid", int'(tach_valid), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_state", int'(fan_state), 0);
        @(negedge ACLK); #2 ARESETN = 1'b1;
        cyc(10);
        enable = 1'b1; duty = 8'd64; tmode = 1;
        wait_valid();
        measure(-1, hi); chk("kick_high", hi, 256);
        repeat (4) wait_valid();
        chk("run_count", int'(tach_count), 10);
        chk("run_state", int'(fan_state), 2);
        measure(-1, hi);  chk("run_duty64", hi, 64);
        measure(200, hi); chk("duty_chg_cur", hi, 64);
        measure(-1, hi);  chk("duty_chg_next", hi, 200);
        tmode = 0;
        for (int i = 0; i < 5000 && !stall; i++) @(negedge ACLK);
        chk("stall_set", int'(stall), 1);
        chk("stall_state", int'(fan_state), 1);
        stall_clr = 1'b1; @(negedge ACLK); stall_clr = 1'b0;
        chk("stall_clr", int'(stall), 0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 1100 && (m_n % WIN) != WIN - 1; i++) @(negedge ACLK);
            stall_clr = 1'b1; @(negedge ACLK); stall_clr = 1'b0;
            if (stall) break;
        end
        chk("stall_set_wins", int'(stall), 1);
        tmode = 2;
        repeat (2) wait_valid();
        chk("glitch_count", int'(tach_count), 0);
        tmode = 4;
        repeat (3) wait_valid();
        chk("terminal_edge", int'(tach_count), 1);
        for (int k = 0; k < 40; k++) begin
            enable = $urandom_range(0, 9) != 0;
            case ($urandom_range(0, 3))
                0: duty = 8'd0;
                1: duty = 8'hFF;
                default: duty = 8'($urandom_range(1, 254));
            endcase
            tmode = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin stall_clr = 1'b1; @(negedge ACLK); stall_clr = 1'b0; end
            cyc($urandom_range(50, 600));
        end
        enable = 1'b1; duty = 8'd128; tmode = 1;
        for (int i = 0; i < 6000 && fan_state != 2'b10; i++) @(negedge ACLK);
        chk("pre_reset_run", int'(fan_state), 2);
        for (int i = 0; i < 300 && !pwm_out; i++) @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_count", int'(tach_count), 0);
        chk("arst_state", int'(fan_state), 0);
        chk("arst_stall", int'(stall), 0);
        cyc(2); #2 ARESETN = 1'b1;
        cyc(5);
        chk("rekick_state", int'(fan_state), 1);
        repeat (2) wait_valid();
        chk("post_reset_count", int'(tach_count), 10);
        @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
